// File: rtl/line_solver_ctrl.sv
// Per-line option sweep for the nonogram solver: streams candidate options from
// option memory through the external checker and folds survivors into cell masks.
module line_solver_ctrl #(
    parameter int SIZE     = 8,
    parameter int MAX_OPTS = 64,
    parameter int AW       = $clog2(MAX_OPTS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW:0]     num_opts,
    input  logic [SIZE-1:0] assigned,
    input  logic [SIZE-1:0] known,
    output logic            opt_rd_en,
    output logic [AW-1:0]   opt_addr,
    input  logic [SIZE-1:0] opt_data,
    output logic            chk_valid_in,
    output logic [SIZE-1:0] chk_option,
    output logic [SIZE-1:0] chk_assigned,
    output logic [SIZE-1:0] chk_known,
    input  logic            chk_valid,
    input  logic            chk_contradict,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     survivors,
    output logic            line_contradict,
    output logic [SIZE-1:0] new_known,
    output logic [SIZE-1:0] new_assigned,
    output logic [1:0]      dbg_state
);

    // Handshake: there is no back-pressure anywhere. opt_rd_en/opt_addr are a
    // one-cycle request whose data arrives the next cycle; chk_valid_in is a
    // one-cycle strobe whose result (chk_valid/chk_contradict) arrives the next cycle.

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [AW-1:0]   base_l;
    logic [AW:0]     num_l;
    logic [SIZE-1:0] assigned_l;
    logic [SIZE-1:0] known_l;
    logic [AW:0]     issue_cnt;
    logic [AW:0]     resp_cnt;
    logic [AW:0]     surv_cnt;
    logic [SIZE-1:0] and_mask;
    logic [SIZE-1:0] or_mask;
    logic [SIZE-1:0] opt_d;

    logic            acc_en;
    logic            keep;
    logic [AW:0]     issue_inc;
    logic [AW:0]     resp_nxt;
    logic [AW:0]     surv_nxt;
    logic [SIZE-1:0] and_nxt;
    logic [SIZE-1:0] or_nxt;
    logic            accept;
    logic            enter_finish;

    logic [AW:0]     res_surv;
    logic [SIZE-1:0] res_and;
    logic [SIZE-1:0] res_or;
    logic [SIZE-1:0] res_known;
    logic [SIZE-1:0] res_asg;
    logic [SIZE-1:0] res_nk;
    logic [SIZE-1:0] res_na;

    assign dbg_state    = state;
    assign opt_rd_en    = (state == S_ISSUE);
    assign busy         = (state == S_ISSUE) || (state == S_DRAIN);
    assign done         = (state == S_FINISH);
    assign opt_addr     = opt_rd_en ? (base_l + issue_cnt[AW-1:0]) : '0;
    assign chk_option   = chk_valid_in ? opt_data : '0;
    assign chk_assigned = busy ? assigned_l : '0;
    assign chk_known    = busy ? known_l : '0;

    always_comb begin
        acc_en    = chk_valid && busy;
        keep      = acc_en && !chk_contradict;
        issue_inc = issue_cnt + {{AW{1'b0}}, 1'b1};
        resp_nxt  = resp_cnt + {{AW{1'b0}}, acc_en};
        surv_nxt  = surv_cnt + {{AW{1'b0}}, keep};
        and_nxt   = keep ? (and_mask & opt_d) : and_mask;
        or_nxt    = keep ? (or_mask | opt_d) : or_mask;
        accept    = (state == S_IDLE) && start;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_opts == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_inc == num_l) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (resp_nxt == num_l) begin
                    state_nxt = S_FINISH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        enter_finish = (state_nxt == S_FINISH) && (state != S_FINISH);
    end

    // Results are registered on the edge into FINISH so they are already valid
    // while done is high; the last checker response is folded in via the *_nxt terms.
    always_comb begin
        if (state == S_IDLE) begin
            res_surv  = '0;
            res_and   = '1;
            res_or    = '0;
            res_known = known;
            res_asg   = assigned;
        end else begin
            res_surv  = surv_nxt;
            res_and   = and_nxt;
            res_or    = or_nxt;
            res_known = known_l;
            res_asg   = assigned_l;
        end
        res_nk = (res_surv != '0) ? (~res_known & (res_and | ~res_or)) : '0;
        res_na = (res_asg & res_known) | (res_and & res_nk);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            base_l          <= '0;
            num_l           <= '0;
            assigned_l      <= '0;
            known_l         <= '0;
            issue_cnt       <= '0;
            resp_cnt        <= '0;
            surv_cnt        <= '0;
            and_mask        <= '1;
            or_mask         <= '0;
            opt_d           <= '0;
            chk_valid_in    <= 1'b0;
            survivors       <= '0;
            line_contradict <= 1'b0;
            new_known       <= '0;
            new_assigned    <= '0;
        end else begin
            state        <= state_nxt;
            chk_valid_in <= opt_rd_en;
            opt_d        <= chk_option;

            if (accept) begin
                base_l          <= base_addr;
                num_l           <= num_opts;
                assigned_l      <= assigned;
                known_l         <= known;
                issue_cnt       <= '0;
                resp_cnt        <= '0;
                surv_cnt        <= '0;
                and_mask        <= '1;
                or_mask         <= '0;
                survivors       <= '0;
                line_contradict <= 1'b0;
                new_known       <= '0;
                new_assigned    <= '0;
            end else begin
                if (opt_rd_en) begin
                    issue_cnt <= issue_inc;
                end
                if (acc_en) begin
                    resp_cnt <= resp_nxt;
                    surv_cnt <= surv_nxt;
                    and_mask <= and_nxt;
                    or_mask  <= or_nxt;
                end
            end

            if (enter_finish) begin
                survivors       <= res_surv;
                line_contradict <= (res_surv == '0);
                new_known       <= res_nk;
                new_assigned    <= res_na;
            end
        end
    end

endmodule

// File: doc/line_solver_ctrl.md
Name: line_solver_ctrl

Overview:
- Sequences the per-line option check for the nonogram solver.
- On `start`, streams a line's candidate options from option memory through the external `simplify` checker, one option per cycle.
- Counts surviving (non-contradicting) options and accumulates their AND/OR masks.
- Reports newly determined cells, the updated assignment, and a line contradiction when no option survives.

Parameters:
- SIZE, 8, line length in cells; width of option/assigned/known.
- MAX_OPTS, 64, maximum options per line.
- AW, $clog2(MAX_OPTS), option memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch pulse; sampled only in IDLE.
- base_addr  in  AW  first option address; sampled at start.
- num_opts  in  AW+1  number of options (0..MAX_OPTS); sampled at start.
- assigned  in  SIZE  current cell values; sampled at start.
- known  in  SIZE  mask of determined cells; sampled at start.
- opt_rd_en  out  1  option memory read strobe.
- opt_addr  out  AW  option memory read address.
- opt_data  in  SIZE  read data; valid exactly 1 cycle after opt_rd_en.
- chk_valid_in  out  1  checker input strobe.
- chk_option  out  SIZE  option presented to the checker.
- chk_assigned  out  SIZE  latched assigned value.
- chk_known  out  SIZE  latched known value.
- chk_valid  in  1  checker result strobe; exactly 1 cycle after chk_valid_in.
- chk_contradict  in  1  1 = option conflicts with assigned on known cells.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- survivors  out  AW+1  count of non-contradicting options.
- line_contradict  out  1  survivors == 0.
- new_known  out  SIZE  cells newly determined by this pass.
- new_assigned  out  SIZE  updated assignment.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, including opt_addr, chk_*, survivors, new_known and new_assigned.
  - Accumulators: and_mask = all-ones, or_mask = 0.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - On start, latch the inputs, clear issue and response counters, reset the accumulators.
  - If num_opts == 0, go to FINISH; otherwise go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - Assert opt_rd_en with opt_addr = base_addr + issue_cnt (mod 2^AW, wraps).
  - Issue one read per cycle, no bubbles.
  - After the num_opts-th read, go to DRAIN.
- Read/check pipeline:
  - chk_valid_in = opt_rd_en delayed 1 cycle.
  - chk_option = opt_data, combinational pass-through in that cycle.
  - chk_assigned and chk_known are driven from the latched copies the whole time busy is high.
- Accumulation, on each chk_valid:
  - Increment resp_cnt.
  - If chk_contradict == 0: survivors++, and_mask &= option, or_mask |= option.
  - The option used is delayed 1 cycle to align with chk_valid.
  - chk_valid outside ISSUE/DRAIN is ignored.
- DRAIN: wait until resp_cnt == num_opts, then go to FINISH.
- FINISH (one cycle), then IDLE:
  - Pulse done; drop busy.
  - Register the results:
    - line_contradict = (survivors == 0).
    - If survivors > 0: new_known = ~known & (and_mask | ~or_mask).
    - Otherwise new_known = 0.
    - new_assigned = (assigned & known) | (and_mask & new_known).
- Result outputs hold until the next start is accepted; they are then cleared to 0 with busy.
- Latency:
  - start sampled at cycle 0.
  - Reads at cycles 1..N, checks at 2..N+1, results at 3..N+2.
  - done at cycle N+3. For N = 0, done at cycle 1.
- Throughput: 1 option per cycle. survivors saturates at num_opts, which is ≤ MAX_OPTS, so there is no overflow.
- rst mid-operation: abort immediately to IDLE with reset values; in-flight checker responses are ignored.
- start asserted in the same cycle as done: ignored, because the FSM is not yet in IDLE.

Test Plan:
- Reset then idle, no start → busy=0, done=0, opt_rd_en=0, all outputs 0 for 10 cycles.
- SIZE=3, assigned=001, known=101, options {111,001,011} at base_addr 4:
  - Expect opt_addr 4,5,6 on consecutive cycles, done at cycle 6.
  - Expect survivors=2, line_contradict=0, new_known=000, new_assigned=001.
- Same line, options {011,111} → survivors=1, new_known=010, new_assigned=011.
- All options contradicting, e.g. {100,110} → survivors=0, line_contradict=1, new_known=000.
- num_opts=0 → done at cycle 1, line_contradict=1; zero opt_rd_en pulses.
- base_addr = MAX_OPTS-1, num_opts=3 → addresses 63,0,1 (wrap).
- Assert rst at cycle 3 of a 5-option run → IDLE next cycle, outputs 0, no done; a subsequent start runs normally.
- Bench checker model: chk_contradict = |((option ^ assigned) & known), 1-cycle latency.
